// File: rtl/regfile_pkg.sv
// regfile_pkg: default widths, the x0 index constant and register index/data types
package regfile_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;
  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] reg_data_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits; issue sets, writeback clears, set beats clear; drives rbusy and iss_stl
module regfile_scoreboard import regfile_pkg::*; #(
  parameter int ADDR = ADDR_W,
  parameter int NR = 2,
  parameter int NW = 2,
  parameter int BYPASS = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic [NW-1:0] we,
  input  logic [NW*ADDR-1:0] wa,
  input  logic [NW-1:0] wclr,
  input  logic [NR*ADDR-1:0] ra,
  input  logic iss_vld,
  input  logic [ADDR-1:0] iss_rd,
  output logic [NR-1:0] rbusy,
  output logic iss_stl
);
  localparam int DEPTH = 2**ADDR;
  logic [DEPTH-1:0] busy_q, busy_d, clr, set, eff;
  always_comb begin
    clr = '0;
    for (int k = 0; k < NW; k++)
      if (we[k] && wclr[k] && wa[k*ADDR +: ADDR] != '0) clr[wa[k*ADDR +: ADDR]] = 1'b1;
  end
  // same-cycle clears are visible to rbusy/iss_stl only with bypass, so writeback costs no bubble
  assign eff = (BYPASS != 0) ? (busy_q & ~clr) : busy_q;
  assign iss_stl = iss_vld && iss_rd != '0 && eff[iss_rd];
  always_comb begin
    set = '0;
    if (iss_vld && iss_rd != '0 && !iss_stl) set[iss_rd] = 1'b1;
  end
  // a new producer issued this cycle outranks a writeback of the old one
  assign busy_d = (busy_q & ~clr) | set;
  always_ff @(posedge clk)
    if (rst) busy_q <= '0;
    else busy_q <= busy_d;
  for (genvar j = 0; j < NR; j++) begin : g_rb
    assign rbusy[j] = eff[ra[j*ADDR +: ADDR]];
  end
endmodule

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-port register file with x0 hardwired to zero, write priority, optional bypass and busy scoreboard
module regfile_mp_sb import regfile_pkg::*; #(
  parameter int DATA = DATA_W,
  parameter int ADDR = ADDR_W,
  parameter int NR = 2,
  parameter int NW = 2,
  parameter int BYPASS = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic [NW-1:0] we,
  input  logic [NW*ADDR-1:0] wa,
  input  logic [NW*DATA-1:0] wd,
  input  logic [NW-1:0] wclr,
  input  logic [NR*ADDR-1:0] ra,
  output logic [NR*DATA-1:0] rd,
  output logic [NR-1:0] rbusy,
  input  logic iss_vld,
  input  logic [ADDR-1:0] iss_rd,
  output logic iss_stl
);
  localparam int DEPTH = 2**ADDR;
  logic [DATA-1:0] mem_q [DEPTH];
  // ascending port order lets the highest-index write win on address collisions
  always_ff @(posedge clk)
    if (rst) for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    else
      for (int k = 0; k < NW; k++)
        if (we[k] && wa[k*ADDR +: ADDR] != '0) mem_q[wa[k*ADDR +: ADDR]] <= wd[k*DATA +: DATA];
  for (genvar j = 0; j < NR; j++) begin : g_rd
    logic [ADDR-1:0] a;
    logic [DATA-1:0] r;
    assign a = ra[j*ADDR +: ADDR];
    always_comb begin
      r = (a == '0) ? '0 : mem_q[a];
      for (int k = 0; k < NW; k++)
        if (BYPASS != 0 && we[k] && a != '0 && wa[k*ADDR +: ADDR] == a) r = wd[k*DATA +: DATA];
    end
    assign rd[j*DATA +: DATA] = r;
  end
  regfile_scoreboard #(.ADDR(ADDR), .NR(NR), .NW(NW), .BYPASS(BYPASS)) u_sb (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wclr(wclr), .ra(ra),
    .iss_vld(iss_vld), .iss_rd(iss_rd), .rbusy(rbusy), .iss_stl(iss_stl)
  );
endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb_regfile_mp_sb: scoreboard bench comparing bypass and non-bypass instances against a spec-level model
module tb_regfile_mp_sb;
  localparam int NR = 4, NW = 3, A = 5, D = 32, DEPTH = 32;
  logic clk = 0, rst = 0;
  logic [NW-1:0] we = '0, wclr = '0;
  logic [NW*A-1:0] wa = '0;
  logic [NW*D-1:0] wd = '0;
  logic [NR*A-1:0] ra = '0;
  logic iss_vld = 0;
  logic [A-1:0] iss_rd = '0;
  logic [NR*D-1:0] rd1, rd0;
  logic [NR-1:0] rb1, rb0;
  logic s1, s0;
  always #5 clk = ~clk;
  regfile_mp_sb #(.DATA(D), .ADDR(A), .NR(NR), .NW(NW), .BYPASS(1)) dut1 (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .wclr(wclr), .ra(ra), .rd(rd1),
    .rbusy(rb1), .iss_vld(iss_vld), .iss_rd(iss_rd), .iss_stl(s1));
  regfile_mp_sb #(.DATA(D), .ADDR(A), .NR(NR), .NW(NW), .BYPASS(0)) dut0 (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .wclr(wclr), .ra(ra), .rd(rd0),
    .rbusy(rb0), .iss_vld(iss_vld), .iss_rd(iss_rd), .iss_stl(s0));
  typedef struct {
    logic [NR*D-1:0] rd1, rd0;
    logic [NR-1:0] rb1, rb0;
    logic s1, s0;
  } exp_t;
  exp_t q[$];
  int vecs = 0, errs = 0;
  logic [D-1:0] mem [DEPTH];
  bit bz [2][DEPTH];
  bit last_stl = 0;
  function automatic int wad(int k); return int'(wa[k*A +: A]); endfunction
  function automatic logic [D-1:0] m_rd(int a, int byp);
    if (a == 0) return '0;
    if (byp != 0)
      for (int k = NW-1; k >= 0; k--) if (we[k] && wad(k) == a) return wd[k*D +: D];
    return mem[a];
  endfunction
  function automatic bit m_clr(int a);
    for (int k = 0; k < NW; k++) if (we[k] && wclr[k] && a != 0 && wad(k) == a) return 1;
    return 0;
  endfunction
  function automatic bit m_busy(int a, int byp);
    return bz[byp][a] && !(byp != 0 && m_clr(a));
  endfunction
  function automatic bit m_stl(int byp);
    return iss_vld && iss_rd != 0 && m_busy(int'(iss_rd), byp);
  endfunction
  task automatic step(input bit chk);
    exp_t e;
    bit st [2];
    if (chk) begin
      for (int j = 0; j < NR; j++) begin
        e.rd1[j*D +: D] = m_rd(int'(ra[j*A +: A]), 1);
        e.rd0[j*D +: D] = m_rd(int'(ra[j*A +: A]), 0);
        e.rb1[j] = m_busy(int'(ra[j*A +: A]), 1);
        e.rb0[j] = m_busy(int'(ra[j*A +: A]), 0);
      end
      e.s1 = m_stl(1);
      e.s0 = m_stl(0);
      q.push_back(e);
    end
    st[0] = m_stl(0);
    st[1] = m_stl(1);
    last_stl = st[1];
    @(posedge clk);
    if (rst) begin
      for (int a = 0; a < DEPTH; a++) begin
        mem[a] = '0;
        bz[0][a] = 0;
        bz[1][a] = 0;
      end
    end else begin
      for (int b = 0; b < 2; b++) begin
        for (int a = 1; a < DEPTH; a++) if (m_clr(a)) bz[b][a] = 0;
        if (iss_vld && iss_rd != 0 && !st[b]) bz[b][iss_rd] = 1;
      end
      for (int k = 0; k < NW; k++) if (we[k] && wad(k) != 0) mem[wad(k)] = wd[k*D +: D];
    end
    #1;
  endtask
  task automatic idle();
    rst = 0; we = '0; wclr = '0; iss_vld = 0;
  endtask
  task automatic cmp(input string nm, input logic [NR*D-1:0] got, input logic [NR*D-1:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
    end
  endtask
  initial forever begin
    @(negedge clk);
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      cmp("rd_byp", rd1, e.rd1);
      cmp("rd_nobyp", rd0, e.rd0);
      cmp("rbusy_byp", {{(NR*D-NR){1'b0}}, rb1}, {{(NR*D-NR){1'b0}}, e.rb1});
      cmp("rbusy_nobyp", {{(NR*D-NR){1'b0}}, rb0}, {{(NR*D-NR){1'b0}}, e.rb0});
      cmp("stl_byp", {{(NR*D-1){1'b0}}, s1}, {{(NR*D-1){1'b0}}, e.s1});
      cmp("stl_nobyp", {{(NR*D-1){1'b0}}, s0}, {{(NR*D-1){1'b0}}, e.s0});
    end
  end
  task automatic rand_in(input int amax);
    for (int k = 0; k < NW; k++) begin
      wa[k*A +: A] = A'($urandom_range(amax));
      wd[k*D +: D] = $urandom;
    end
    for (int j = 0; j < NR; j++) ra[j*A +: A] = A'($urandom_range(amax));
    we = NW'($urandom);
    wclr = NW'($urandom);
    if (!(iss_vld && last_stl)) begin
      iss_vld = $urandom_range(1) == 1;
      iss_rd = A'($urandom_range(amax));
    end
  endtask
  initial begin
    for (int a = 0; a < DEPTH; a++) mem[a] = '0;
    #1;
    rst = 1;
    step(0);
    idle();
    for (int i = 0; i < 6; i++) begin rand_in(31); step(1); end
    rst = 1;
    step(1);
    idle();
    for (int i = 0; i < 4; i++) begin rand_in(31); we = '0; iss_vld = 0; step(1); end
    we = 3'b011; wa = {5'd0, 5'd5, 5'd5}; wd = {32'd0, 32'h5555, 32'hAAAA};
    step(1);
    idle();
    ra = {5'd0, 5'd0, 5'd0, 5'd5};
    step(1);
    we = 3'b001; wa = {5'd0, 5'd0, 5'd0}; wd = {64'd0, 32'hFFFF};
    step(1);
    idle();
    step(1);
    we = 3'b001; wa = {5'd0, 5'd0, 5'd7}; wd = {64'd0, 32'h1234}; ra = {5'd0, 5'd0, 5'd0, 5'd7};
    step(1);
    idle();
    step(1);
    iss_vld = 1; iss_rd = 5'd9; ra = {5'd9, 5'd9, 5'd9, 5'd9};
    step(1);
    step(1);
    we = 3'b001; wclr = 3'b001; wa = {5'd0, 5'd0, 5'd9};
    step(1);
    idle();
    step(1);
    iss_vld = 1; iss_rd = 5'd3; we = 3'b001; wclr = 3'b001; wa = {5'd0, 5'd0, 5'd3};
    ra = {5'd0, 5'd0, 5'd3, 5'd3};
    step(1);
    idle();
    step(1);
    iss_vld = 1; iss_rd = 5'd0; ra = '0;
    step(1);
    step(1);
    idle();
    step(1);
    for (int i = 0; i < 10000; i++) begin
      rand_in(($urandom_range(3) == 0) ? 31 : 7);
      rst = $urandom_range(199) == 0;
      step(1);
    end
    idle();
    step(1);
    @(negedge clk);
    @(posedge clk);
    if (q.size() != 0) begin
      errs++;
      $display("FAIL drain got=%0d pending exp=0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
